instr_encoder: RTL and testbench
================================

# instr_encoder

Instruction encoder and program loader, the inverse of the main decoder: it accepts one symbolic instruction request per handshake (kind plus fields), packs it into the 32-bit MIPS word whose opcode the main decoder recognises, and writes the words to instruction memory at consecutive word addresses. It sits between the bench or boot controller and the instruction-memory write port, and is used to load programs before the core is released from reset.

## Interface
- ADDR_W, 32, byte-address width of the memory write port
- BASE_ADDR, 0, byte address of the first word written after `start`
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a load session (honoured in IDLE and DONE only)
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid & ready
- req_kind  in  3  0=R_TYPE 1=LW 2=SW 3=BEQ 4=J 5=ADDI; 6,7 illegal
- req_last  in  1  final request of the session
- req_rs, req_rt, req_rd  in  5 each  register fields
- req_funct  in  6  R-type funct
- req_imm  in  16  I-type immediate
- req_target  in  26  J-type target
- mem_we  out  1  write request
- mem_ready  in  1  memory accepts the write when mem_we & mem_ready
- mem_addr  out  ADDR_W  byte address of the current write
- mem_wdata  out  32  encoded instruction
- busy  out  1  state is LOAD or DRAIN
- done  out  1  level; session complete
- err_illegal  out  1  sticky; an illegal kind was received this session
- word_count  out  ADDR_W  words written this session

## Operation
- Encodings:
  - R_TYPE: {000000, rs, rt, rd, 00000, funct}
  - LW: {100011, rs, rt, imm}
  - SW: {101011, rs, rt, imm}
  - BEQ: {000100, rs, rt, imm}
  - ADDI: {001000, rs, rt, imm}
  - J: {000010, target}
  - Unused fields of a kind are ignored.
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE or DONE, on `start`: go to LOAD; mem_addr←BASE_ADDR, word_count←0, err_illegal←0, done←0.
  - LOAD: req_ready = FIFO not full (at most one free entry is needed). On an accepted request, legal kinds push the encoded word into the FIFO. An illegal kind is consumed without a push and sets err_illegal. An accepted request with req_last set moves the FSM to DRAIN; this holds for legal and illegal kinds.
  - DRAIN: req_ready=0. When the FIFO is empty and no write is pending, go to DONE.
  - DONE: done=1; wait for `start`.
- Write side: mem_we = FIFO non-empty, and mem_wdata = FIFO head. On mem_we & mem_ready:
  - pop the head,
  - mem_addr ← mem_addr+4, wrapping modulo 2^ADDR_W,
  - word_count ← word_count+1, wrapping.
- `start` while in LOAD or DRAIN is ignored.
- Push and pop in the same cycle are both honoured.

## Timing
- Reset values: req_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err_illegal=0, word_count=0. State is IDLE and the FIFO is empty.
- An rst_n assertion mid-session aborts immediately. FIFO contents are discarded and no further writes are made.
- Latency from request acceptance at edge N: mem_we is asserted in cycle N+1 with that word.
- Sustained throughput is one word per cycle while mem_ready=1.
- mem_we, mem_addr and mem_wdata hold stable while mem_ready=0.
- The `start` pulse at edge N gives busy=1 and req_ready=1 from cycle N+1.
- done rises in the cycle after the last write completes. If every remaining request was illegal, it rises in the cycle after the FIFO is seen empty in DRAIN.

## Structure
- Shared package `mips_defs`:
  - opcode constants (R_TYPE, LW, SW, BEQ, J, ADDI),
  - the req_kind encoding,
  - the FSM state encoding.
  
  The main decoder and this block both use the opcode constants from it.
- One sub-module: `instr_fifo2`, a 2-entry 32-bit FIFO with full and empty flags.
- The encoder is combinational logic inside `instr_encoder`, ahead of the FIFO push.

## Test plan
- start with BASE_ADDR=0x100, then ADDI rs=0 rt=8 imm=5 with last=1 -> one write of 0x20080005 @0x100; done=1 and word_count=1.
- Back-to-back LW rs=8 rt=9 imm=4, SW rs=8 rt=9 imm=8, BEQ rs=8 rt=9 imm=2, J target=0x10, R rs=8 rt=9 rd=10 funct=0x20, with mem_ready=1 -> 0x8D090004, 0x AD090008, 0x11090002, 0x08000010, 0x01095020 on consecutive cycles @0x100..0x110.
- Hold mem_ready=0 for 5 cycles during a stream -> req_ready drops after 2 buffered words; mem_addr and mem_wdata stay stable; no word is lost or duplicated.
- kind=7 between two ADDIs -> err_illegal=1; only 2 writes occur, at consecutive addresses; illegal kind with last=1 still reaches DONE.
- ADDR_W=8 with BASE_ADDR=0xFC, 2 words -> writes land at 0xFC then 0x00.
- rst_n low mid-stream with the FIFO full -> all outputs return to reset values at once; no write after reset; a new start works normally.

Source files
------------

// File: rtl/mips_defs.sv
// Opcodes, request kinds and loader FSM states shared by the main decoder and
// the instruction encoder.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [2:0] {
    KIND_R    = 3'd0,
    KIND_LW   = 3'd1,
    KIND_SW   = 3'd2,
    KIND_BEQ  = 3'd3,
    KIND_J    = 3'd4,
    KIND_ADDI = 3'd5
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic kind_is_legal(input logic [2:0] kind);
    return kind <= 3'd5;
  endfunction

endpackage

// File: rtl/instr_fifo2.sv
// Two-entry 32-bit FIFO between the encoder and the memory write port; the
// head is always presented on dout so the write side sees it without delay.
module instr_fifo2 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [31:0] din,
  input  logic        pop,
  output logic [31:0] dout,
  output logic        full,
  output logic        empty
);

  logic [31:0] mem_r [2];
  logic        wptr_r;
  logic        rptr_r;
  logic [1:0]  count_r;
  logic        push_en_s;
  logic        pop_en_s;

  assign full      = (count_r == 2'd2);
  assign empty     = (count_r == 2'd0);
  assign push_en_s = push & ~full;
  assign pop_en_s  = pop & ~empty;
  assign dout      = mem_r[rptr_r];

  // Storage, pointers and occupancy; push and pop in one cycle leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r[0] <= 32'h0000_0000;
      mem_r[1] <= 32'h0000_0000;
      wptr_r   <= 1'b0;
      rptr_r   <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_en_s) begin
        mem_r[wptr_r] <= din;
        wptr_r        <= ~wptr_r;
      end
      if (pop_en_s) begin
        rptr_r <= ~rptr_r;
      end
      case ({push_en_s, pop_en_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: packs symbolic instruction requests into MIPS words and
// writes them to instruction memory at consecutive word addresses.
module instr_encoder
  import mips_defs::*;
#(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_kind,
  input  logic              req_last,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [5:0]        req_funct,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic [ADDR_W-1:0] word_count
);

  state_e            state_r;
  state_e            next_state_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              accept_s;
  logic              legal_s;
  logic              push_s;
  logic              pop_s;
  logic              start_ok_s;
  logic [31:0]       enc_word_s;
  logic              busy_r;
  logic              done_r;
  logic              err_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] count_r;

  assign req_ready   = (state_r == ST_LOAD) & ~fifo_full_s;
  assign accept_s    = req_valid & req_ready;
  assign legal_s     = kind_is_legal(req_kind);
  assign push_s      = accept_s & legal_s;
  assign mem_we      = ~fifo_empty_s;
  assign pop_s       = mem_we & mem_ready;
  assign start_ok_s  = start & ((state_r == ST_IDLE) | (state_r == ST_DONE));

  assign busy        = busy_r;
  assign done        = done_r;
  assign err_illegal = err_r;
  assign mem_addr    = addr_r;
  assign word_count  = count_r;

  // Field packing per request kind; illegal kinds never reach the FIFO.
  always_comb begin
    enc_word_s = 32'h0000_0000;
    case (req_kind)
      KIND_R:    enc_word_s = {OP_RTYPE, req_rs, req_rt, req_rd, 5'b00000, req_funct};
      KIND_LW:   enc_word_s = {OP_LW, req_rs, req_rt, req_imm};
      KIND_SW:   enc_word_s = {OP_SW, req_rs, req_rt, req_imm};
      KIND_BEQ:  enc_word_s = {OP_BEQ, req_rs, req_rt, req_imm};
      KIND_J:    enc_word_s = {OP_J, req_target};
      KIND_ADDI: enc_word_s = {OP_ADDI, req_rs, req_rt, req_imm};
      default:   enc_word_s = 32'h0000_0000;
    endcase
  end

  // Next-state logic of the session FSM.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) next_state_s = ST_LOAD;
        else       next_state_s = state_r;
      end
      ST_LOAD: begin
        if (accept_s && req_last) next_state_s = ST_DRAIN;
        else                      next_state_s = ST_LOAD;
      end
      ST_DRAIN: begin
        if (fifo_empty_s) next_state_s = ST_DONE;
        else              next_state_s = ST_DRAIN;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register with busy/done flopped from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == ST_LOAD) || (next_state_s == ST_DRAIN);
      done_r  <= (next_state_s == ST_DONE);
    end
  end

  // Write address, word counter and sticky illegal flag; start only arrives with the FIFO empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r  <= {ADDR_W{1'b0}};
      count_r <= {ADDR_W{1'b0}};
      err_r   <= 1'b0;
    end else if (start_ok_s) begin
      addr_r  <= BASE_ADDR;
      count_r <= {ADDR_W{1'b0}};
      err_r   <= 1'b0;
    end else begin
      if (pop_s) begin
        addr_r  <= addr_r + ADDR_W'(32'd4);
        count_r <= count_r + ADDR_W'(32'd1);
      end
      if (accept_s && !legal_s) begin
        err_r <= 1'b1;
      end
    end
  end

  instr_fifo2 u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .din   (enc_word_s),
    .pop   (pop_s),
    .dout  (mem_wdata),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed requests push expected writes,
// a monitor pops and compares on every memory handshake.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n, start, req_valid, req_ready, req_last;
  logic [2:0]  req_kind;
  logic [4:0]  req_rs, req_rt, req_rd;
  logic [5:0]  req_funct;
  logic [15:0] req_imm;
  logic [25:0] req_target;
  logic        mem_we, mem_ready, busy, done, err_illegal;
  logic [31:0] mem_addr, mem_wdata, word_count;

  logic        start8, req_valid8, req_ready8, req_last8;
  logic [2:0]  req_kind8;
  logic [4:0]  req_rt8;
  logic [15:0] req_imm8;
  logic        mem_we8, mem_ready8, busy8, done8, err8;
  logic [7:0]  mem_addr8, word_count8;
  logic [31:0] mem_wdata8;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  exp_t        q8[$];
  exp_t        mon_e, mon_e8;
  int          wcyc[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_addr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_last(req_last), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_funct(req_funct), .req_imm(req_imm), .req_target(req_target), .mem_we(mem_we),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .err_illegal(err_illegal), .word_count(word_count)
  );

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(8'hFC)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .req_valid(req_valid8), .req_ready(req_ready8),
    .req_kind(req_kind8), .req_last(req_last8), .req_rs(5'd0), .req_rt(req_rt8), .req_rd(5'd0),
    .req_funct(6'd0), .req_imm(req_imm8), .req_target(26'd0), .mem_we(mem_we8),
    .mem_ready(mem_ready8), .mem_addr(mem_addr8), .mem_wdata(mem_wdata8), .busy(busy8), .done(done8),
    .err_illegal(err8), .word_count(word_count8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor for the 32-bit instance
  always @(negedge clk) begin
    if (mem_we && mem_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
      end else begin
        mon_e = q.pop_front();
        check("wr_addr", {32'h0, mem_addr}, {32'h0, mon_e.addr});
        check("wr_data", {32'h0, mem_wdata}, {32'h0, mon_e.data});
        wcyc.push_back(cyc);
      end
    end
  end

  // Monitor for the 8-bit-address instance
  always @(negedge clk) begin
    if (mem_we8 && mem_ready8) begin
      if (q8.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write8: got addr %0h data %0h expected no write", mem_addr8, mem_wdata8);
      end else begin
        mon_e8 = q8.pop_front();
        check("wr8_addr", {56'h0, mem_addr8}, {56'h0, mon_e8.addr[7:0]});
        check("wr8_data", {32'h0, mem_wdata8}, {32'h0, mon_e8.data});
      end
    end
  end

  task automatic do_start();
    start = 1'b1;
    exp_addr = 32'h0000_0100;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_after_start", {63'h0, busy}, 64'h1);
    check("ready_after_start", {63'h0, req_ready}, 64'h1);
    check("done_cleared", {63'h0, done}, 64'h0);
  endtask

  task automatic drive(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [5:0] f, input logic [15:0] imm,
                       input logic [25:0] tgt, input bit last, input logic [31:0] w);
    if (k <= 3'd5) begin
      q.push_back('{exp_addr, w});
      exp_addr = exp_addr + 32'd4;
    end
    req_kind = k; req_rs = rs; req_rt = rt; req_rd = rd; req_funct = f;
    req_imm = imm; req_target = tgt; req_last = last; req_valid = 1'b1;
  endtask

  task automatic wait_accept();
    bit ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = req_ready;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got req_ready 0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_last = 1'b0;
  endtask

  task automatic send(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [5:0] f, input logic [15:0] imm,
                      input logic [25:0] tgt, input bit last, input logic [31:0] w);
    drive(k, rs, rt, rd, f, imm, tgt, last, w);
    wait_accept();
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = done;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got done 0 expected 1 within 50 cycles");
    end
    check("queue_drained", q.size(), 64'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [4:0] rt, input logic [15:0] imm, input bit last);
    bit ok = 1'b0;
    req_kind8 = 3'd5; req_rt8 = rt; req_imm8 = imm; req_last8 = last; req_valid8 = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = req_ready8;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept8_timeout: got req_ready 0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1 req_valid8 = 1'b0;
    req_last8 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; req_valid = 1'b0; req_last = 1'b0; req_kind = 3'd0;
    req_rs = 5'd0; req_rt = 5'd0; req_rd = 5'd0; req_funct = 6'd0; req_imm = 16'd0;
    req_target = 26'd0; mem_ready = 1'b1; exp_addr = 32'h0000_0100;
    start8 = 1'b0; req_valid8 = 1'b0; req_last8 = 1'b0; req_kind8 = 3'd0;
    req_rt8 = 5'd0; req_imm8 = 16'd0; mem_ready8 = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_req_ready", {63'h0, req_ready}, 64'h0);
    check("rst_mem_we", {63'h0, mem_we}, 64'h0);
    check("rst_mem_addr", {32'h0, mem_addr}, 64'h0);
    check("rst_mem_wdata", {32'h0, mem_wdata}, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    check("rst_err", {63'h0, err_illegal}, 64'h0);
    check("rst_word_count", {32'h0, word_count}, 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single ADDI session
    do_start();
    send(3'd5, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0, 1'b1, 32'h2008_0005);
    wait_done();
    check("t1_word_count", {32'h0, word_count}, 64'h1);
    check("t1_next_addr", {32'h0, mem_addr}, 64'h104);
    check("t1_err", {63'h0, err_illegal}, 64'h0);
    check("t1_busy", {63'h0, busy}, 64'h0);

    // Back-to-back kinds at full throughput
    wcyc.delete();
    do_start();
    send(3'd1, 5'd8, 5'd9, 5'd0, 6'd0, 16'd4, 26'd0, 1'b0, 32'h8D09_0004);
    send(3'd2, 5'd8, 5'd9, 5'd0, 6'd0, 16'd8, 26'd0, 1'b0, 32'hAD09_0008);
    send(3'd3, 5'd8, 5'd9, 5'd0, 6'd0, 16'd2, 26'd0, 1'b0, 32'h1109_0002);
    send(3'd4, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 1'b0, 32'h0800_0010);
    send(3'd0, 5'd8, 5'd9, 5'd10, 6'h20, 16'd0, 26'd0, 1'b1, 32'h0109_5020);
    wait_done();
    check("t2_word_count", {32'h0, word_count}, 64'h5);
    check("t2_writes", wcyc.size(), 64'h5);
    for (int i = 1; i < wcyc.size(); i++) begin
      check("t2_gap", wcyc[i] - wcyc[i-1], 64'h1);
    end

    // Backpressure: memory stalls while the FIFO fills
    mem_ready = 1'b0;
    do_start();
    send(3'd5, 5'd0, 5'd1, 5'd0, 6'd0, 16'd1, 26'd0, 1'b0, 32'h2001_0001);
    send(3'd5, 5'd0, 5'd2, 5'd0, 6'd0, 16'd2, 26'd0, 1'b0, 32'h2002_0002);
    drive(3'd5, 5'd0, 5'd3, 5'd0, 6'd0, 16'd3, 26'd0, 1'b1, 32'h2003_0003);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_ready_low", {63'h0, req_ready}, 64'h0);
      check("t3_we_held", {63'h0, mem_we}, 64'h1);
      check("t3_addr_held", {32'h0, mem_addr}, 64'h100);
      check("t3_data_held", {32'h0, mem_wdata}, 64'h2001_0001);
    end
    @(posedge clk);
    #1 mem_ready = 1'b1;
    wait_accept();
    wait_done();
    check("t3_word_count", {32'h0, word_count}, 64'h3);

    // Illegal kind between legal ones, then an illegal-only session
    do_start();
    send(3'd5, 5'd0, 5'd4, 5'd0, 6'd0, 16'd7, 26'd0, 1'b0, 32'h2004_0007);
    send(3'd7, 5'd1, 5'd2, 5'd3, 6'd4, 16'd5, 26'd6, 1'b0, 32'h0);
    send(3'd5, 5'd0, 5'd5, 5'd0, 6'd0, 16'd9, 26'd0, 1'b1, 32'h2005_0009);
    wait_done();
    check("t4_err", {63'h0, err_illegal}, 64'h1);
    check("t4_word_count", {32'h0, word_count}, 64'h2);
    do_start();
    check("t4_err_cleared", {63'h0, err_illegal}, 64'h0);
    send(3'd6, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b1, 32'h0);
    wait_done();
    check("t4b_err", {63'h0, err_illegal}, 64'h1);
    check("t4b_word_count", {32'h0, word_count}, 64'h0);

    // Address wrap with an 8-bit address port
    start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    q8.push_back('{32'h0000_00FC, 32'h2001_0001});
    q8.push_back('{32'h0000_0000, 32'h2002_0002});
    send8(5'd1, 16'd1, 1'b0);
    send8(5'd2, 16'd2, 1'b1);
    for (int n = 0; n < 50 && !done8; n++) @(negedge clk);
    check("t5_done8", {63'h0, done8}, 64'h1);
    check("t5_word_count8", {56'h0, word_count8}, 64'h2);
    check("t5_addr8", {56'h0, mem_addr8}, 64'h04);
    check("t5_queue8", q8.size(), 64'h0);
    @(posedge clk);
    #1;

    // Reset mid-session with the FIFO full
    mem_ready = 1'b0;
    do_start();
    send(3'd5, 5'd0, 5'd6, 5'd0, 6'd0, 16'd6, 26'd0, 1'b0, 32'h2006_0006);
    send(3'd5, 5'd0, 5'd7, 5'd0, 6'd0, 16'd7, 26'd0, 1'b0, 32'h2007_0007);
    check("t6_full", {63'h0, req_ready}, 64'h0);
    rst_n = 1'b0;
    #1;
    q.delete();
    check("t6_mem_we", {63'h0, mem_we}, 64'h0);
    check("t6_mem_addr", {32'h0, mem_addr}, 64'h0);
    check("t6_mem_wdata", {32'h0, mem_wdata}, 64'h0);
    check("t6_busy", {63'h0, busy}, 64'h0);
    check("t6_ready", {63'h0, req_ready}, 64'h0);
    check("t6_word_count", {32'h0, word_count}, 64'h0);
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_no_write", {63'h0, mem_we}, 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_start();
    send(3'd5, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0, 1'b1, 32'h2008_0005);
    wait_done();
    check("t6_restart_count", {32'h0, word_count}, 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
